// File: rtl/legv8_multicycle_core_if.sv
// LEGv8 multicycle core bus: instruction and data req/ack ports
// plus retire and halt status.
interface legv8_multicycle_core_if #(
    parameter int XLEN = 64
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            imem_ack;
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [XLEN-1:0] dmem_rdata;
    logic            dmem_ack;
    logic            retire;
    logic [XLEN-1:0] retire_pc;
    logic            halted;
    logic            illegal;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata, imem_ack,
        output dmem_req, dmem_we,
        output dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack,
        output retire, retire_pc,
        output halted, illegal
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata, imem_ack,
        input  dmem_req, dmem_we,
        input  dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack,
        input  retire, retire_pc,
        input  halted, illegal
    );
endinterface

// File: rtl/legv8_multicycle_core.sv
// Multi-cycle LEGv8 subset core: FETCH/DECODE/EXEC/MEM/WB/HALT
// sequencing over stallable req/ack instruction and data memories.
module legv8_multicycle_core #(
    parameter int              XLEN     = 64,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic clk,
    input  logic reset,
    legv8_multicycle_core_if.master bus
);
    localparam int            RW = $clog2(NREGS);
    localparam logic [RW-1:0] ZR = RW'(NREGS - 1);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC,
        S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_ORR,
        OP_LDUR, OP_STUR, OP_CB, OP_B
    } op_t;

    state_t          state_q;
    op_t             op_q;
    op_t             dec_op;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     ir_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] res_q;
    logic [XLEN-1:0] imm_q;
    logic            cbnz_q;
    logic [XLEN-1:0] rf_q [NREGS];
    logic            retire_q;
    logic [XLEN-1:0] retire_pc_q;
    logic            halted_q;
    logic            illegal_q;

    logic [XLEN-1:0] dec_imm;
    logic            dec_ok;
    logic            dec_hlt;
    logic            dec_cbnz;
    logic            dec_use_rt;
    logic [RW-1:0]   rn;
    logic [RW-1:0]   rm;
    logic [RW-1:0]   rt;
    logic [XLEN-1:0] rn_val;
    logic [XLEN-1:0] rm_val;
    logic [XLEN-1:0] rt_val;
    logic [XLEN-1:0] alu_y;
    logic [XLEN-1:0] pc_plus4;
    logic            cb_take;
    logic            fetch;
    logic            unused;

    // Upper register-field bits beyond log2(NREGS) are dropped here
    assign rn = ir_q[5 +: RW];
    assign rm = ir_q[16 +: RW];
    assign rt = ir_q[0 +: RW];

    assign rn_val = (rn == ZR) ? '0 : rf_q[rn];
    assign rm_val = (rm == ZR) ? '0 : rf_q[rm];
    assign rt_val = (rt == ZR) ? '0 : rf_q[rt];

    assign pc_plus4 = pc_q + XLEN'(4);
    assign cb_take  = cbnz_q ? (b_q != '0) : (b_q == '0);
    assign unused   = ^ir_q;

    always_comb begin
        dec_op     = OP_ADD;
        dec_imm    = '0;
        dec_ok     = 1'b1;
        dec_hlt    = 1'b0;
        dec_cbnz   = 1'b0;
        dec_use_rt = 1'b0;
        unique case (1'b1)
            ir_q[31:21] == 11'b10001011000: dec_op = OP_ADD;
            ir_q[31:21] == 11'b11001011000: dec_op = OP_SUB;
            ir_q[31:21] == 11'b10001010000: dec_op = OP_AND;
            ir_q[31:21] == 11'b10101010000: dec_op = OP_ORR;
            ir_q[31:21] == 11'b11111000010: begin
                dec_op  = OP_LDUR;
                dec_imm = {{(XLEN-9){ir_q[20]}}, ir_q[20:12]};
            end
            ir_q[31:21] == 11'b11111000000: begin
                dec_op     = OP_STUR;
                dec_imm    = {{(XLEN-9){ir_q[20]}}, ir_q[20:12]};
                dec_use_rt = 1'b1;
            end
            ir_q[31:21] == 11'b11010100010: dec_hlt = 1'b1;
            ir_q[31:24] == 8'b10110100: begin
                dec_op     = OP_CB;
                dec_imm    = {{(XLEN-21){ir_q[23]}}, ir_q[23:5], 2'b00};
                dec_use_rt = 1'b1;
            end
            ir_q[31:24] == 8'b10110101: begin
                dec_op     = OP_CB;
                dec_cbnz   = 1'b1;
                dec_imm    = {{(XLEN-21){ir_q[23]}}, ir_q[23:5], 2'b00};
                dec_use_rt = 1'b1;
            end
            ir_q[31:26] == 6'b000101: begin
                dec_op  = OP_B;
                dec_imm = {{(XLEN-28){ir_q[25]}}, ir_q[25:0], 2'b00};
            end
            default: dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        alu_y = a_q + b_q;
        unique case (op_q)
            OP_SUB:  alu_y = a_q - b_q;
            OP_AND:  alu_y = a_q & b_q;
            OP_ORR:  alu_y = a_q | b_q;
            default: alu_y = a_q + b_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            op_q        <= OP_ADD;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            imm_q       <= '0;
            cbnz_q      <= 1'b0;
            retire_q    <= 1'b0;
            retire_pc_q <= '0;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            retire_q <= 1'b0;
            unique case (state_q)
                S_FETCH: begin
                    if (bus.imem_ack) begin
                        ir_q    <= bus.imem_rdata;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q    <= rn_val;
                    b_q    <= dec_use_rt ? rt_val : rm_val;
                    imm_q  <= dec_imm;
                    op_q   <= dec_op;
                    cbnz_q <= dec_cbnz;
                    if (!dec_ok || dec_hlt) begin
                        state_q   <= S_HALT;
                        halted_q  <= 1'b1;
                        illegal_q <= !dec_ok;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    unique case (op_q)
                        OP_LDUR, OP_STUR: begin
                            res_q   <= a_q + imm_q;
                            state_q <= S_MEM;
                        end
                        OP_CB, OP_B: begin
                            if (op_q == OP_B || cb_take) begin
                                pc_q <= pc_q + imm_q;
                            end else begin
                                pc_q <= pc_plus4;
                            end
                            retire_q    <= 1'b1;
                            retire_pc_q <= pc_q;
                            state_q     <= S_FETCH;
                        end
                        default: begin
                            res_q   <= alu_y;
                            state_q <= S_WB;
                        end
                    endcase
                end
                S_MEM: begin
                    if (bus.dmem_ack) begin
                        if (op_q == OP_LDUR) begin
                            res_q   <= bus.dmem_rdata;
                            state_q <= S_WB;
                        end else begin
                            pc_q        <= pc_plus4;
                            retire_q    <= 1'b1;
                            retire_pc_q <= pc_q;
                            state_q     <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    if (rt != ZR) begin
                        rf_q[rt] <= res_q;
                    end
                    pc_q        <= pc_plus4;
                    retire_q    <= 1'b1;
                    retire_pc_q <= pc_q;
                    state_q     <= S_FETCH;
                end
                default: state_q <= S_HALT;
            endcase
        end
    end

    // Fetch request is gated by reset so it drops with no clock edge
    assign fetch          = (state_q == S_FETCH) && !reset;
    assign bus.imem_req   = fetch;
    assign bus.imem_addr  = fetch ? pc_q : '0;
    assign bus.dmem_req   = (state_q == S_MEM);
    assign bus.dmem_we    = (state_q == S_MEM) && (op_q == OP_STUR);
    assign bus.dmem_addr  = res_q;
    assign bus.dmem_wdata = b_q;
    assign bus.retire     = retire_q;
    assign bus.retire_pc  = retire_pc_q;
    assign bus.halted     = halted_q;
    assign bus.illegal    = illegal_q;
endmodule

// File: tb/tb_legv8_multicycle_core.sv
// Directed bench for legv8_multicycle_core: 64-bit build with stalling
// memories plus a 32-bit/16-register build with RESET_PC=0x100.
module tb_legv8_multicycle_core;
  typedef struct {
    logic [31:0] ins;
    int          lat;
    bit          mem;
  } pe_t;

  typedef struct {
    int          addr;
    logic [63:0] val;
  } dm_t;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] nxt;
    int          lat;
  } br_t;

  localparam logic [10:0] O_ADD  = 11'b10001011000;
  localparam logic [10:0] O_SUB  = 11'b11001011000;
  localparam logic [10:0] O_AND  = 11'b10001010000;
  localparam logic [10:0] O_ORR  = 11'b10101010000;
  localparam logic [10:0] O_LDUR = 11'b11111000010;
  localparam logic [10:0] O_STUR = 11'b11111000000;
  localparam logic [31:0] HLT    = 32'hD4400000;
  localparam int XZR = 31;
  localparam int NP  = 19;
  localparam int ND  = 10;
  localparam int NB  = 8;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  legv8_multicycle_core_if #(.XLEN(64)) busa ();
  legv8_multicycle_core_if #(.XLEN(32)) busb ();

  legv8_multicycle_core #(
    .XLEN(64), .NREGS(32), .RESET_PC(64'h0)
  ) u_a (
    .clk(clk), .reset(rst_a), .bus(busa)
  );

  legv8_multicycle_core #(
    .XLEN(32), .NREGS(16), .RESET_PC(32'h100)
  ) u_b (
    .clk(clk), .reset(rst_b), .bus(busb)
  );

  logic [31:0] imem_a [256];
  logic [63:0] dmem_a [256];
  logic [31:0] imem_b [256];
  logic [31:0] dmem_b [256];
  int iw_a, dw_a, iw_b, dw_b;
  int ic_a, dc_a, ic_b, dc_b;
  int nchk = 0;
  int nerr = 0;
  int cyc_a, cyc_b;
  logic [63:0] rpc_a [$];
  logic [63:0] rnx_a [$];
  int          rcyc_a [$];
  int halt_req_a, hold13, hold_bad;
  int nret_b, cyc1_b;
  logic [31:0] pc1_b, nx1_b;

  pe_t prog [NP];
  dm_t dexp [ND];
  br_t btr [NB];
  int  wi [3];
  int  wd [3];

  function automatic logic [31:0] r_ins(
    input logic [10:0] op, input int rm, input int rn, input int rd);
    return {op, rm[4:0], 6'd0, rn[4:0], rd[4:0]};
  endfunction

  function automatic logic [31:0] d_ins(
    input logic [10:0] op, input int imm, input int rn, input int rt);
    return {op, imm[8:0], 2'b00, rn[4:0], rt[4:0]};
  endfunction

  function automatic logic [31:0] cb_ins(
    input logic [7:0] op, input int imm, input int rt);
    return {op, imm[18:0], rt[4:0]};
  endfunction

  function automatic logic [31:0] b_ins(input int imm);
    return {6'b000101, imm[25:0]};
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory models: ack after a programmable number of req cycles
  initial begin
    ic_a = 0; dc_a = 0;
    busa.imem_ack = 1'b0; busa.dmem_ack = 1'b0;
    busa.imem_rdata = '0; busa.dmem_rdata = '0;
    forever begin
      @(negedge clk);
      busa.imem_ack = 1'b0;
      busa.dmem_ack = 1'b0;
      if (busa.imem_req) begin
        if (ic_a >= iw_a) begin
          busa.imem_ack = 1'b1;
          busa.imem_rdata = imem_a[busa.imem_addr[9:2]];
          ic_a = 0;
        end else ic_a++;
      end else ic_a = 0;
      if (busa.dmem_req) begin
        if (dc_a >= dw_a) begin
          busa.dmem_ack = 1'b1;
          dc_a = 0;
          if (busa.dmem_we)
            dmem_a[busa.dmem_addr[7:0]] = busa.dmem_wdata;
          else
            busa.dmem_rdata = dmem_a[busa.dmem_addr[7:0]];
        end else dc_a++;
      end else dc_a = 0;
    end
  end

  initial begin
    ic_b = 0; dc_b = 0;
    busb.imem_ack = 1'b0; busb.dmem_ack = 1'b0;
    busb.imem_rdata = '0; busb.dmem_rdata = '0;
    forever begin
      @(negedge clk);
      busb.imem_ack = 1'b0;
      busb.dmem_ack = 1'b0;
      if (busb.imem_req) begin
        if (ic_b >= iw_b) begin
          busb.imem_ack = 1'b1;
          busb.imem_rdata = imem_b[busb.imem_addr[9:2]];
          ic_b = 0;
        end else ic_b++;
      end else ic_b = 0;
      if (busb.dmem_req) begin
        if (dc_b >= dw_b) begin
          busb.dmem_ack = 1'b1;
          dc_b = 0;
          if (busb.dmem_we)
            dmem_b[busb.dmem_addr[7:0]] = busb.dmem_wdata;
          else
            busb.dmem_rdata = dmem_b[busb.dmem_addr[7:0]];
        end else dc_b++;
      end else dc_b = 0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc_a = rst_a ? 0 : cyc_a + 1;
      cyc_b = rst_b ? 0 : cyc_b + 1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (busa.retire) begin
        rpc_a.push_back(busa.retire_pc);
        rnx_a.push_back(busa.imem_addr);
        rcyc_a.push_back(cyc_a);
      end
      if (busa.halted &&
          (busa.imem_req || busa.dmem_req || busa.retire))
        halt_req_a++;
      if (busa.dmem_req && busa.dmem_we &&
          busa.dmem_addr == 64'd13) begin
        hold13++;
        if (busa.dmem_wdata != 64'd12) hold_bad++;
      end
      if (busb.retire) begin
        if (nret_b == 0) begin
          pc1_b  = busb.retire_pc;
          nx1_b  = busb.imem_addr;
          cyc1_b = cyc_b;
        end
        nret_b++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic run_a(input int iw, input int dw);
    @(posedge clk);
    #1 rst_a = 1'b1;
    #1 chk("rst_halted_async", busa.halted, 0);
    iw_a = iw;
    dw_a = dw;
    rpc_a.delete();
    rnx_a.delete();
    rcyc_a.delete();
    halt_req_a = 0;
    hold13 = 0;
    hold_bad = 0;
    @(posedge clk);
    #1 rst_a = 1'b0;
    for (int i = 0; i < 3000 && !busa.halted; i++)
      @(negedge clk);
    chk("halt_reached", busa.halted, 1);
    repeat (6) @(negedge clk);
  endtask

  task automatic load_main();
    for (int i = 0; i < 256; i++) begin
      imem_a[i] = 32'h0;
      dmem_a[i] = 64'h0;
    end
    for (int k = 0; k < NP; k++) imem_a[k] = prog[k].ins;
    imem_a[NP] = HLT;
    dmem_a[0]  = 64'd5;
    dmem_a[8]  = 64'd7;
    dmem_a[40] = 64'hDEAD;
  endtask

  initial begin
    prog[0]  = '{32'h8B020023, 4, 1'b0};
    prog[1]  = '{d_ins(O_LDUR, 0, XZR, 1), 5, 1'b1};
    prog[2]  = '{d_ins(O_LDUR, 8, XZR, 2), 5, 1'b1};
    prog[3]  = '{r_ins(O_ADD, 2, 1, 3), 4, 1'b0};
    prog[4]  = '{d_ins(O_STUR, 8, 1, 3), 4, 1'b1};
    prog[5]  = '{d_ins(O_LDUR, 8, 1, 4), 5, 1'b1};
    prog[6]  = '{d_ins(O_STUR, 16, XZR, 4), 4, 1'b1};
    prog[7]  = '{r_ins(O_SUB, 1, 2, 7), 4, 1'b0};
    prog[8]  = '{d_ins(O_STUR, 24, XZR, 7), 4, 1'b1};
    prog[9]  = '{r_ins(O_ADD, 2, 1, XZR), 4, 1'b0};
    prog[10] = '{r_ins(O_ADD, 1, XZR, 6), 4, 1'b0};
    prog[11] = '{d_ins(O_STUR, 32, XZR, 6), 4, 1'b1};
    prog[12] = '{d_ins(O_STUR, 40, XZR, XZR), 4, 1'b1};
    prog[13] = '{r_ins(O_AND, 2, 1, 8), 4, 1'b0};
    prog[14] = '{r_ins(O_ORR, 2, 1, 9), 4, 1'b0};
    prog[15] = '{d_ins(O_STUR, 48, XZR, 8), 4, 1'b1};
    prog[16] = '{d_ins(O_STUR, 56, XZR, 9), 4, 1'b1};
    prog[17] = '{r_ins(O_SUB, 2, 1, 10), 4, 1'b0};
    prog[18] = '{d_ins(O_STUR, 64, XZR, 10), 4, 1'b1};

    dexp[0] = '{0, 64'd5};
    dexp[1] = '{8, 64'd7};
    dexp[2] = '{13, 64'd12};
    dexp[3] = '{16, 64'd12};
    dexp[4] = '{24, 64'd2};
    dexp[5] = '{32, 64'd5};
    dexp[6] = '{40, 64'd0};
    dexp[7] = '{48, 64'd5};
    dexp[8] = '{56, 64'd7};
    dexp[9] = '{64, 64'hFFFF_FFFF_FFFF_FFFE};

    btr[0] = '{64'h00, 64'h10, 3};
    btr[1] = '{64'h10, 64'h1C, 3};
    btr[2] = '{64'h1C, 64'h20, 5};
    btr[3] = '{64'h20, 64'h10, 3};
    btr[4] = '{64'h10, 64'h14, 3};
    btr[5] = '{64'h14, 64'h24, 3};
    btr[6] = '{64'h24, 64'h28, 3};
    btr[7] = '{64'h28, 64'h08, 3};

    wi = '{0, 0, 2};
    wd = '{0, 3, 1};
    iw_a = 0; dw_a = 0; iw_b = 0; dw_b = 0;
    nret_b = 0;

    @(negedge clk);
    chk("rst_imem_req", busa.imem_req, 0);
    chk("rst_imem_addr", busa.imem_addr, 0);
    chk("rst_dmem_req", busa.dmem_req, 0);
    chk("rst_retire", busa.retire, 0);
    chk("rst_halted", busa.halted, 0);
    chk("rst_b_req", busb.imem_req, 0);

    for (int r = 0; r < 3; r++) begin
      load_main();
      run_a(wi[r], wd[r]);
      chk($sformatf("r%0d_count", r), rpc_a.size(), NP);
      for (int k = 0; k < NP && k < rpc_a.size(); k++) begin
        int el, prev;
        el = prog[k].lat + wi[r] + (prog[k].mem ? wd[r] : 0);
        prev = (k == 0) ? 0 : rcyc_a[k-1];
        chk($sformatf("r%0d_pc%0d", r, k), rpc_a[k], 4 * k);
        chk($sformatf("r%0d_next%0d", r, k),
            rnx_a[k], 4 * k + 4);
        chk($sformatf("r%0d_lat%0d", r, k),
            rcyc_a[k] - prev, el);
      end
      for (int d = 0; d < ND; d++)
        chk($sformatf("r%0d_mem%0d", r, dexp[d].addr),
            dmem_a[dexp[d].addr], dexp[d].val);
      chk($sformatf("r%0d_illegal", r), busa.illegal, 0);
      chk($sformatf("r%0d_halt_quiet", r), halt_req_a, 0);
      chk($sformatf("r%0d_hold13", r), hold13, wd[r] + 1);
      chk($sformatf("r%0d_hold_data", r), hold_bad, 0);
    end

    for (int i = 0; i < 256; i++) begin
      imem_a[i] = 32'h0;
      dmem_a[i] = 64'h0;
    end
    imem_a[0]  = b_ins(4);
    imem_a[2]  = HLT;
    imem_a[4]  = cb_ins(8'b10110100, 3, 5);
    imem_a[5]  = cb_ins(8'b10110101, 4, 5);
    imem_a[7]  = d_ins(O_LDUR, 0, XZR, 5);
    imem_a[8]  = b_ins(-4);
    imem_a[9]  = cb_ins(8'b10110101, 2, XZR);
    imem_a[10] = b_ins(-8);
    dmem_a[0]  = 64'd1;
    run_a(0, 0);
    chk("br_count", rpc_a.size(), NB);
    for (int k = 0; k < NB && k < rpc_a.size(); k++) begin
      int prev;
      prev = (k == 0) ? 0 : rcyc_a[k-1];
      chk($sformatf("br_pc%0d", k), rpc_a[k], btr[k].pc);
      chk($sformatf("br_next%0d", k), rnx_a[k], btr[k].nxt);
      chk($sformatf("br_lat%0d", k), rcyc_a[k] - prev, btr[k].lat);
    end
    chk("br_illegal", busa.illegal, 0);

    imem_a[0] = 32'hFFFF_FFFF;
    run_a(0, 0);
    chk("ill_flag", busa.illegal, 1);
    chk("ill_halted", busa.halted, 1);
    chk("ill_no_retire", rpc_a.size(), 0);
    chk("ill_quiet", halt_req_a, 0);

    for (int i = 0; i < 256; i++) begin
      imem_b[i] = 32'h0;
      dmem_b[i] = 32'h0;
    end
    imem_b[64] = 32'h8B020023;
    imem_b[65] = d_ins(O_LDUR, 0, XZR, 1);
    imem_b[66] = d_ins(O_LDUR, 8, XZR, 2);
    imem_b[67] = r_ins(O_ADD, 2, 1, 3);
    imem_b[68] = d_ins(O_STUR, 16, XZR, 3);
    imem_b[69] = HLT;
    dmem_b[0] = 32'd5;
    dmem_b[8] = 32'd7;
    iw_b = 1000;
    @(posedge clk);
    #1 rst_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("b_req_stall", busb.imem_req, 1);
    chk("b_addr_stall", busb.imem_addr, 32'h100);
    #2 rst_b = 1'b1;
    #1 chk("b_req_async", busb.imem_req, 0);
    chk("b_addr_async", busb.imem_addr, 0);
    iw_b = 0;
    nret_b = 0;
    @(posedge clk);
    #1 rst_b = 1'b0;
    for (int i = 0; i < 1000 && !busb.halted; i++)
      @(negedge clk);
    repeat (3) @(negedge clk);
    chk("b_halted", busb.halted, 1);
    chk("b_illegal", busb.illegal, 0);
    chk("b_count", nret_b, 5);
    chk("b_pc1", pc1_b, 32'h100);
    chk("b_cyc1", cyc1_b, 4);
    chk("b_next1", nx1_b, 32'h104);
    chk("b_sum", dmem_b[16], 32'd12);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
